lcd_cmd_sequencer: RTL and testbench
====================================

Name: lcd_cmd_sequencer

Overview:
- Upstream stage of the LCD controller. It takes a queued command stream from the host and issues one command at a time on the controller's cmd/cmd_valid/busy handshake.
- On a LOAD command it streams the 108-byte (12x9) image from an external synchronous image memory straight onto datain, one byte per cycle, with exact alignment to the controller's load window.
- Rejects illegal opcodes and reports idle/error status to the host.

Parameters:
- FIFO_DEPTH, 4, host command FIFO entries (power of 2, at least 2).
- IMG_SIZE, 108, bytes per image load.
- CMD_MAX, 9, highest legal opcode (0=LOAD … 9=REFRESH).
- BUSY_TIMEOUT, 3, cycles to wait for busy to rise after an issue before flagging an error.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- host_cmd  in  4  opcode pushed by the host.
- host_cmd_valid  in  1  push strobe; accepted only when host_cmd_ready=1.
- host_cmd_ready  out  1  FIFO not full.
- img_addr  out  7  image memory address.
- img_rd  out  1  image memory read enable.
- img_data  in  8  memory read data, valid the cycle after img_addr/img_rd are sampled.
- cmd  out  4  opcode to the LCD controller.
- cmd_valid  out  1  single-cycle issue strobe.
- datain  out  8  pixel byte to the controller; combinationally equal to img_data.
- busy  in  1  controller busy.
- seq_idle  out  1  FIFO empty, FSM in IDLE, and busy=0.
- err_illegal  out  1  sticky; set by a dropped opcode greater than CMD_MAX.
- err_timeout  out  1  sticky; set when busy fails to rise after an issue.

Behaviour:
- Reset, applied synchronously on any cycle including mid-stream:
  - FIFO emptied; FSM to IDLE.
  - cmd=0, cmd_valid=0, img_rd=0, img_addr=0.
  - err_illegal=0, err_timeout=0, host_cmd_ready=1, seq_idle=1.
- FIFO:
  - A push happens when host_cmd_valid and host_cmd_ready are both high.
  - An opcode greater than CMD_MAX is not stored and sets err_illegal.
  - Push and pop in the same cycle are allowed when the FIFO is full; the count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, ISSUE, STREAM, WAIT_RISE, WAIT_FALL.
- IDLE: if the FIFO is non-empty and busy=0, pop the head and go to ISSUE.
- ISSUE (exactly 1 cycle):
  - cmd_valid=1 and cmd=head opcode.
  - For LOAD (0): also img_rd=1 and img_addr=0, then go to STREAM.
  - For any other opcode: go to WAIT_RISE.
- STREAM:
  - img_rd=1; img_addr increments each cycle from 1 to IMG_SIZE-1.
  - The controller samples byte k at the k+1-th rising edge after the issue edge.
  - After the cycle with img_addr=IMG_SIZE-1, img_rd=0 and go to WAIT_FALL.
  - busy is ignored during STREAM.
- WAIT_RISE:
  - When busy=1, go to WAIT_FALL.
  - If BUSY_TIMEOUT cycles pass with busy=0, set err_timeout and return to IDLE.
- WAIT_FALL: when busy=0, go to IDLE. Because busy falls as the controller returns to its command state, the next issue may occur the cycle after.
- Issue spacing: cmd_valid is never asserted in two consecutive cycles. The guard states cover the one-cycle lag of busy.
- img_addr is 7-bit and stops at 107; it never wraps within a stream.
- A host push during STREAM or the WAIT states is queued normally.

Decomposition:
- Shared package lcd_pkg holds the opcode constants LOAD through REFRESH, IMG_W=12, IMG_H=9, and IMG_SIZE=108. These are shared with the LCD controller.
- One sub-module, lcd_cmd_fifo: a synchronous FIFO with full/empty flags and a depth parameter.
- The FSM and address counter stay in lcd_cmd_sequencer.

Test Plan:
- Push LOAD with memory pattern data[a]=a+1 and a controller model -> one cmd_valid with cmd=0; img_addr steps 0..107 over 108 consecutive cycles; the model captures bytes 1..108 in order; seq_idle=1 after the model's 16-pixel refresh.
- Push LOAD, 5 (SHIFT_RIGHT), 3 (ZOOM_IN) back-to-back -> three cmd_valid pulses in order, each only after busy fell; no consecutive-cycle pulses.
- Push 5 opcodes with FIFO_DEPTH=4 while the controller is busy -> host_cmd_ready=0 after the 4th; the 5th is held until a pop; none are lost.
- Push opcode 12 -> not queued; err_illegal=1 and stays 1; a subsequent push of 9 issues normally.
- Issue 7 with a model holding busy at 0 -> err_timeout=1 after 3 cycles; FSM back to IDLE; the next queued command still issues.
- Assert reset at img_addr=50 -> the next cycle has img_rd=0, cmd_valid=0, FIFO empty, seq_idle=1.

Source files
------------

// File: rtl/lcd_pkg.sv
// lcd_pkg: constants shared between the command sequencer and the LCD
// controller.
//   - Opcode values LOAD (0) through REFRESH (9).
//   - Image geometry: IMG_W x IMG_H pixels, IMG_SIZE bytes per load.
package lcd_pkg;

   localparam int IMG_W    = 12;
   localparam int IMG_H    = 9;
   localparam int IMG_SIZE = IMG_W * IMG_H;

   localparam logic [3:0] OP_LOAD        = 4'd0;
   localparam logic [3:0] OP_SHIFT_UP    = 4'd1;
   localparam logic [3:0] OP_SHIFT_DOWN  = 4'd2;
   localparam logic [3:0] OP_ZOOM_IN     = 4'd3;
   localparam logic [3:0] OP_ZOOM_OUT    = 4'd4;
   localparam logic [3:0] OP_SHIFT_RIGHT = 4'd5;
   localparam logic [3:0] OP_SHIFT_LEFT  = 4'd6;
   localparam logic [3:0] OP_AVERAGE     = 4'd7;
   localparam logic [3:0] OP_INVERT      = 4'd8;
   localparam logic [3:0] OP_REFRESH     = 4'd9;

endpackage

// File: rtl/lcd_cmd_sequencer_if.sv
// lcd_cmd_sequencer_if: command handshake between the sequencer and the LCD
// controller.
//   cmd       opcode being issued
//   cmd_valid single-cycle issue strobe
//   datain    pixel byte streamed during a LOAD
//   busy      controller busy
// Handshake: the controller samples cmd on the rising edge where cmd_valid=1
// and raises busy from the following cycle. The sequencer issues only while
// busy=0 and never on two consecutive cycles; during a LOAD the controller
// samples byte k of datain on the (k+1)-th rising edge after the issue edge.
// Modports: master = sequencer side, slave = controller side.
interface lcd_cmd_sequencer_if;

   logic [3:0] cmd;
   logic       cmd_valid;
   logic [7:0] datain;
   logic       busy;

   modport master (
      output cmd,
      output cmd_valid,
      output datain,
      input  busy
   );

   modport slave (
      input  cmd,
      input  cmd_valid,
      input  datain,
      output busy
   );

endinterface

// File: rtl/lcd_cmd_fifo.sv
// lcd_cmd_fifo: synchronous FIFO holding host opcodes.
//   clk, reset  clock, synchronous active-high reset (empties the FIFO)
//   push_i      write din_i; honoured when not full, or when full and
//               pop_i is also high in the same cycle
//   din_i       data to write
//   pop_i       drop the head entry (ignored when empty)
//   dout_o      head entry, valid while empty_o=0
//   full_o      DEPTH entries held
//   empty_o     no entries held
// DEPTH must be a power of two so the pointers wrap naturally.
module lcd_cmd_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         push_i,
   input  logic [W-1:0] din_i,
   input  logic         pop_i,
   output logic [W-1:0] dout_o,
   output logic         full_o,
   output logic         empty_o
);

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   cnt_q;
   logic          do_push, do_pop;

   assign full_o  = (cnt_q == FULL_CNT);
   assign empty_o = (cnt_q == '0);
   assign dout_o  = mem_q[rd_q];

   // A push into a full FIFO is legal when the head leaves in the same cycle.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + 1'b1;
         if (do_pop)  rd_q <= rd_q + 1'b1;
         if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
         else if (do_pop && !do_push) cnt_q <= cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= din_i;
   end

endmodule

// File: rtl/lcd_cmd_sequencer.sv
// lcd_cmd_sequencer: upstream stage of the LCD controller. Queues host
// opcodes, issues them one at a time on the controller handshake, and on LOAD
// streams the image memory straight onto datain.
//   clk, reset      clock, synchronous active-high reset
//   host_cmd        opcode pushed by the host
//   host_cmd_valid  push strobe, taken when host_cmd_ready=1
//   host_cmd_ready  FIFO has room (or is being popped this cycle)
//   img_addr        image memory address
//   img_rd          image memory read enable
//   img_data        memory data, valid the cycle after img_addr/img_rd
//   ctl             controller handshake (cmd, cmd_valid, datain, busy)
//   seq_idle        nothing queued, FSM idle and controller not busy
//   err_illegal     sticky: an opcode above CMD_MAX was dropped
//   err_timeout     sticky: busy did not rise after an issue
//   dbg_state_o     current FSM state
module lcd_cmd_sequencer
   import lcd_pkg::OP_LOAD;
#(
   parameter int FIFO_DEPTH   = 4,
   parameter int IMG_SIZE     = lcd_pkg::IMG_SIZE,
   parameter int CMD_MAX      = 9,
   parameter int BUSY_TIMEOUT = 3
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [3:0]                 host_cmd,
   input  logic                       host_cmd_valid,
   output logic                       host_cmd_ready,
   output logic [6:0]                 img_addr,
   output logic                       img_rd,
   input  logic [7:0]                 img_data,
   lcd_cmd_sequencer_if.master        ctl,
   output logic                       seq_idle,
   output logic                       err_illegal,
   output logic                       err_timeout,
   output logic [2:0]                 dbg_state_o
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_ISSUE     = 3'd1;
   localparam logic [2:0] S_STREAM    = 3'd2;
   localparam logic [2:0] S_WAIT_RISE = 3'd3;
   localparam logic [2:0] S_WAIT_FALL = 3'd4;

   localparam logic [6:0]    LAST_ADDR = 7'(IMG_SIZE - 1);
   localparam int            TW        = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
   localparam logic [TW-1:0] LAST_TMO  = TW'(BUSY_TIMEOUT - 1);

   logic [2:0]    state_q, state_d;
   logic [3:0]    cmd_q, cmd_d;
   logic [6:0]    addr_q, addr_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          err_ill_q, err_ill_d;
   logic          err_tmo_q, err_tmo_d;

   logic          fifo_full, fifo_empty;
   logic [3:0]    fifo_head;
   logic          pop, push_acc, op_legal;

   // Pop only from IDLE with the controller free; busy lags an issue by one
   // cycle, which the WAIT states absorb.
   assign pop            = (state_q == S_IDLE) && !fifo_empty && !ctl.busy;
   assign host_cmd_ready = !fifo_full || pop;
   assign push_acc       = host_cmd_valid && host_cmd_ready;
   assign op_legal       = (host_cmd <= 4'(CMD_MAX));

   lcd_cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (4)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push_acc && op_legal),
      .din_i   (host_cmd),
      .pop_i   (pop),
      .dout_o  (fifo_head),
      .full_o  (fifo_full),
      .empty_o (fifo_empty)
   );

   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      addr_d    = addr_q;
      tmo_d     = tmo_q;
      err_ill_d = err_ill_q | (push_acc && !op_legal);
      err_tmo_d = err_tmo_q;
      case (state_q)
         S_IDLE: begin
            if (pop) begin
               cmd_d   = fifo_head;
               state_d = S_ISSUE;
               if (fifo_head == OP_LOAD) addr_d = '0;
            end
         end
         S_ISSUE: begin
            tmo_d = '0;
            if (cmd_q == OP_LOAD) begin
               // Address 0 goes out with the issue itself, so byte k lands
               // on datain for the (k+1)-th edge after the issue edge.
               addr_d  = addr_q + 7'd1;
               state_d = S_STREAM;
            end else begin
               state_d = S_WAIT_RISE;
            end
         end
         S_STREAM: begin
            if (addr_q == LAST_ADDR) state_d = S_WAIT_FALL;
            else                     addr_d  = addr_q + 7'd1;
         end
         S_WAIT_RISE: begin
            if (ctl.busy) begin
               state_d = S_WAIT_FALL;
            end else if (tmo_q == LAST_TMO) begin
               err_tmo_d = 1'b1;
               state_d   = S_IDLE;
            end else begin
               tmo_d = tmo_q + 1'b1;
            end
         end
         S_WAIT_FALL: begin
            if (!ctl.busy) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         cmd_q     <= '0;
         addr_q    <= '0;
         tmo_q     <= '0;
         err_ill_q <= 1'b0;
         err_tmo_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cmd_q     <= cmd_d;
         addr_q    <= addr_d;
         tmo_q     <= tmo_d;
         err_ill_q <= err_ill_d;
         err_tmo_q <= err_tmo_d;
      end
   end

   assign ctl.cmd       = cmd_q;
   assign ctl.cmd_valid = (state_q == S_ISSUE);
   assign ctl.datain    = img_data;
   assign img_rd        = ((state_q == S_ISSUE) && (cmd_q == OP_LOAD)) || (state_q == S_STREAM);
   assign img_addr      = addr_q;
   assign seq_idle      = fifo_empty && (state_q == S_IDLE) && !ctl.busy;
   assign err_illegal   = err_ill_q;
   assign err_timeout   = err_tmo_q;
   assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// tb_lcd_cmd_sequencer: drives host pushes, models the image memory and the
// LCD controller's busy behaviour, and checks issue order, issue spacing,
// LOAD addressing/data alignment, the sticky error flags and reset.
module tb_lcd_cmd_sequencer;
   import lcd_pkg::*;

   localparam int CMD_MAX_TB = 9;
   localparam int BUSY_TMO   = 3;
   localparam int REFRESH_N  = 16;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [3:0] host_cmd;
   logic       host_cmd_valid;
   logic       host_cmd_ready;
   logic [6:0] img_addr;
   logic       img_rd;
   logic [7:0] img_data;
   logic       seq_idle, err_illegal, err_timeout;
   logic [2:0] dbg_state;
   logic       busy_m;

   lcd_cmd_sequencer_if ctl_if ();
   assign ctl_if.busy = busy_m;

   lcd_cmd_sequencer #(
      .FIFO_DEPTH   (4),
      .IMG_SIZE     (IMG_SIZE),
      .CMD_MAX      (CMD_MAX_TB),
      .BUSY_TIMEOUT (BUSY_TMO)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .host_cmd       (host_cmd),
      .host_cmd_valid (host_cmd_valid),
      .host_cmd_ready (host_cmd_ready),
      .img_addr       (img_addr),
      .img_rd         (img_rd),
      .img_data       (img_data),
      .ctl            (ctl_if),
      .seq_idle       (seq_idle),
      .err_illegal    (err_illegal),
      .err_timeout    (err_timeout),
      .dbg_state_o    (dbg_state)
   );

   // ---------------- scoreboard state ----------------
   int         n_cmp = 0;
   int         n_bad = 0;
   logic [3:0] exp_q[$];
   logic [3:0] exp_cmd;
   logic       exp_illegal = 1'b0;
   logic       exp_timeout = 1'b0;
   logic [7:0] mem_arr [IMG_SIZE];

   bit noresp7      = 1'b0;
   int busy_len_min = 1;
   int busy_len_max = 4;
   int busy_cnt     = 0;
   int ld_idx       = -1;
   int tmo_idx      = -1;
   bit prev_cv      = 1'b0;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // ---------------- models ----------------
   // Synchronous image memory: data appears the cycle after the read.
   always @(posedge clk) begin
      if (img_rd) img_data <= (int'(img_addr) < IMG_SIZE) ? mem_arr[img_addr] : 8'h00;
   end

   // Controller: busy rises the cycle after an issue. A LOAD keeps it high for
   // the 108 byte captures plus a 16-pixel refresh; other opcodes hold it for
   // a random number of cycles; opcode 7 can be made to never answer.
   always @(posedge clk) begin
      if (reset) begin
         busy_m   <= 1'b0;
         busy_cnt <= 0;
      end else if (busy_cnt > 0) begin
         if (busy_cnt == 1) busy_m <= 1'b0;
         busy_cnt <= busy_cnt - 1;
      end else if (ctl_if.cmd_valid) begin
         if (ctl_if.cmd == OP_LOAD) begin
            busy_m   <= 1'b1;
            busy_cnt <= IMG_SIZE + REFRESH_N;
         end else if (!(noresp7 && ctl_if.cmd == 4'd7)) begin
            busy_m   <= 1'b1;
            busy_cnt <= int'($urandom_range(busy_len_max, busy_len_min));
         end
      end
   end

   // ---------------- monitor ----------------
   always @(negedge clk) begin
      if (reset) begin
         ld_idx  = -1;
         tmo_idx = -1;
         prev_cv = 1'b0;
      end else begin
         if (ctl_if.cmd_valid) begin
            check_eq("cv_spacing", 32'(prev_cv), 32'd0);
            check_eq("busy_at_issue", 32'(busy_m), 32'd0);
            check_eq("issue_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               exp_cmd = exp_q.pop_front();
               check_eq("cmd_order", 32'(ctl_if.cmd), 32'(exp_cmd));
               if (exp_cmd == OP_LOAD) ld_idx = 0;
               if (noresp7 && exp_cmd == 4'd7) tmo_idx = 0;
            end
         end
         if (ld_idx >= 0) begin
            if (ld_idx < IMG_SIZE)
               check_eq("img_rd_addr", 32'({img_rd, img_addr}), 32'({1'b1, 7'(ld_idx)}));
            else
               check_eq("img_rd_off", 32'(img_rd), 32'd0);
            if (ld_idx >= 1)
               check_eq("load_byte", 32'(ctl_if.datain), 32'(mem_arr[ld_idx-1]));
            if (ld_idx == IMG_SIZE) ld_idx = -1;
            else                    ld_idx++;
         end
         if (tmo_idx >= 0) begin
            if (tmo_idx == BUSY_TMO + 1) begin
               exp_timeout = 1'b1;
               tmo_idx     = -1;
            end else begin
               tmo_idx++;
            end
         end
         check_eq("err_illegal", 32'(err_illegal), 32'(exp_illegal));
         check_eq("err_timeout", 32'(err_timeout), 32'(exp_timeout));
         prev_cv = ctl_if.cmd_valid;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic push_cmd(input logic [3:0] op);
      int n;
      n = 0;
      @(negedge clk);
      host_cmd       = op;
      host_cmd_valid = 1'b1;
      #1;
      while (!host_cmd_ready && n < 3000) begin
         @(negedge clk);
         #1;
         n++;
      end
      check_eq("push_accept", 32'(n < 3000), 32'd1);
      if (n < 3000 && int'(op) <= CMD_MAX_TB) exp_q.push_back(op);
      @(posedge clk);
      #1;
      if (n < 3000 && int'(op) > CMD_MAX_TB) exp_illegal = 1'b1;
      host_cmd_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      reset       = 1'b0;
      exp_illegal = 1'b0;
      exp_timeout = 1'b0;
   endtask

   task automatic wait_drained(input string tag);
      int n;
      n = 0;
      @(negedge clk);
      while (!(seq_idle && exp_q.size() == 0 && ld_idx < 0 && tmo_idx < 0) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      check_eq({tag, "_drain"}, 32'(n < 5000), 32'd1);
   endtask

   task automatic check_reset_state(input string tag);
      check_eq({tag, "_cmd_valid"}, 32'(ctl_if.cmd_valid), 32'd0);
      check_eq({tag, "_cmd"}, 32'(ctl_if.cmd), 32'd0);
      check_eq({tag, "_img_rd"}, 32'(img_rd), 32'd0);
      check_eq({tag, "_img_addr"}, 32'(img_addr), 32'd0);
      check_eq({tag, "_ready"}, 32'(host_cmd_ready), 32'd1);
      check_eq({tag, "_seq_idle"}, 32'(seq_idle), 32'd1);
      check_eq({tag, "_err_ill"}, 32'(err_illegal), 32'd0);
      check_eq({tag, "_err_tmo"}, 32'(err_timeout), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n;
      host_cmd       = 4'd0;
      host_cmd_valid = 1'b0;
      for (int a = 0; a < IMG_SIZE; a++) mem_arr[a] = 8'(a + 1);

      // reset state
      @(negedge clk);
      do_reset();
      @(negedge clk);
      check_reset_state("rst0");

      // single LOAD with data[a]=a+1
      push_cmd(OP_LOAD);
      wait_drained("load1");
      check_eq("load1_idle", 32'(seq_idle), 32'd1);

      // LOAD, SHIFT_RIGHT, ZOOM_IN back to back with a random image
      for (int a = 0; a < IMG_SIZE; a++) mem_arr[a] = 8'($urandom_range(255, 0));
      push_cmd(OP_LOAD);
      push_cmd(OP_SHIFT_RIGHT);
      push_cmd(OP_ZOOM_IN);
      wait_drained("b2b");

      // fill the FIFO while the controller is busy
      busy_len_min = 40;
      busy_len_max = 40;
      push_cmd(4'd2);
      n = 0;
      while (!busy_m && n < 100) begin
         @(negedge clk);
         n++;
      end
      check_eq("full_busy_seen", 32'(busy_m), 32'd1);
      busy_len_min = 1;
      busy_len_max = 4;
      push_cmd(4'd1);
      push_cmd(4'd4);
      push_cmd(4'd6);
      push_cmd(4'd8);
      @(negedge clk);
      check_eq("full_ready", 32'(host_cmd_ready), 32'd0);
      check_eq("full_pending", 32'(exp_q.size()), 32'd4);
      push_cmd(4'd9);
      wait_drained("full");

      // illegal opcode dropped, sticky flag, then a normal issue
      push_cmd(4'd12);
      @(negedge clk);
      check_eq("illegal_set", 32'(err_illegal), 32'd1);
      push_cmd(OP_REFRESH);
      wait_drained("illegal");
      check_eq("illegal_sticky", 32'(err_illegal), 32'd1);

      // busy never rises for opcode 7
      noresp7 = 1'b1;
      push_cmd(4'd7);
      push_cmd(4'd4);
      wait_drained("timeout");
      check_eq("timeout_set", 32'(err_timeout), 32'd1);
      noresp7 = 1'b0;

      // random mix
      for (int i = 0; i < 40; i++) begin
         int r;
         logic [3:0] op;
         r = int'($urandom_range(19, 0));
         if (r == 0)      op = OP_LOAD;
         else if (r == 1) op = 4'(13 + $urandom_range(2, 0));
         else             op = 4'($urandom_range(9, 1));
         push_cmd(op);
         repeat ($urandom_range(3, 0)) @(negedge clk);
      end
      wait_drained("rand");

      // reset in the middle of a LOAD stream with another command queued
      push_cmd(OP_LOAD);
      push_cmd(OP_ZOOM_IN);
      n = 0;
      @(negedge clk);
      while (!(img_rd && img_addr == 7'd50) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check_eq("addr50_seen", 32'(n < 500), 32'd1);
      do_reset();
      @(negedge clk);
      check_reset_state("rst_mid");
      repeat (5) @(negedge clk);
      check_eq("rst_mid_quiet", 32'(seq_idle), 32'd1);
      push_cmd(OP_REFRESH);
      wait_drained("post_rst");

      check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
